// File: rtl/md_unit_param.sv
// -----------------------------------------------------------------------------
// md_unit_param
// Parametrised multiply/divide unit for the E stage. Owns the architectural
// HI/LO registers. An accepted op computes its full result in one step into
// private result registers, then counts down a fixed latency before the
// result is committed to HI/LO. This keeps the pipeline-visible timing the
// same as the older iterative unit.
//
// Ports:
//   clk     in   clock
//   reset   in   synchronous, active-high reset
//   start   in   issue md_op (codes 0-7 only)
//   md_op   in   0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu,
//                6 msub, 7 msubu, 8 mthi, 9 mtlo, 10-15 nop
//   src_a   in   rs operand / dividend / mthi-mtlo data
//   src_b   in   rt operand / divisor
//   cancel  in   exception/eret flush, aborts the in-flight op
//   busy    out  an op is in flight
//   done    out  one-cycle pulse in the cycle after HI/LO commit
//   hi, lo  out  architectural HI/LO
// -----------------------------------------------------------------------------
module md_unit_param #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int DW = 2 * WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_LAT - 1);

    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Two's-complement magnitude of v when neg is set, v otherwise.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
        return neg ? (~v + ONE_W) : v;
    endfunction

    logic [1:0]       state_r;
    logic [3:0]       counter_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] res_hi_r;
    logic [WIDTH-1:0] res_lo_r;
    logic             busy_r;
    logic             done_r;

    logic             is_signed_s;
    logic             is_div_op_s;
    logic [DW-1:0]    a_ext_s;
    logic [DW-1:0]    b_ext_s;
    logic [DW-1:0]    prod_s;
    logic [DW-1:0]    acc_s;
    logic [DW-1:0]    mul_res_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] uquot_s;
    logic [WIDTH-1:0] urem_s;
    logic [WIDTH-1:0] calc_hi_s;
    logic [WIDTH-1:0] calc_lo_s;
    logic             accept_s;

    // Operand preparation plus the one-step multiply and magnitude divide.
    always_comb begin
        // Even codes are the signed variants for both the mul and div groups.
        is_signed_s = ~md_op[0];
        is_div_op_s = (md_op == 4'd2) || (md_op == 4'd3);

        if (is_signed_s) begin
            a_ext_s = {{WIDTH{src_a[WIDTH-1]}}, src_a};
            b_ext_s = {{WIDTH{src_b[WIDTH-1]}}, src_b};
        end else begin
            a_ext_s = {ZERO_W, src_a};
            b_ext_s = {ZERO_W, src_b};
        end
        // Product truncated to 2*WIDTH is exact for both signednesses.
        prod_s = a_ext_s * b_ext_s;
        acc_s  = {hi_r, lo_r};

        case (md_op)
            4'd4, 4'd5: mul_res_s = acc_s + prod_s;
            4'd6, 4'd7: mul_res_s = acc_s - prod_s;
            default:    mul_res_s = prod_s;
        endcase

        a_neg_s = is_signed_s & src_a[WIDTH-1];
        b_neg_s = is_signed_s & src_b[WIDTH-1];
        a_mag_s = magnitude(src_a, a_neg_s);
        // A zero divisor is replaced so the divider never sees /0; the
        // divide-by-zero result is selected separately below.
        if (src_b == ZERO_W) begin
            b_mag_s = ONE_W;
        end else begin
            b_mag_s = magnitude(src_b, b_neg_s);
        end
        uquot_s = a_mag_s / b_mag_s;
        urem_s  = a_mag_s % b_mag_s;
    end

    // Result selection including the defined divide corner cases.
    always_comb begin
        calc_hi_s = mul_res_s[DW-1:WIDTH];
        calc_lo_s = mul_res_s[WIDTH-1:0];
        if (is_div_op_s) begin
            if (src_b == ZERO_W) begin
                calc_lo_s = ALL_ONES;
                calc_hi_s = src_a;
            end else if (is_signed_s && (src_a == MOST_NEG) && (src_b == ALL_ONES)) begin
                calc_lo_s = MOST_NEG;
                calc_hi_s = ZERO_W;
            end else begin
                // Quotient truncates toward zero, remainder follows the dividend.
                calc_lo_s = magnitude(uquot_s, a_neg_s ^ b_neg_s);
                calc_hi_s = magnitude(urem_s, a_neg_s);
            end
        end else begin
            calc_hi_s = mul_res_s[DW-1:WIDTH];
            calc_lo_s = mul_res_s[WIDTH-1:0];
        end
    end

    assign accept_s = (state_r == ST_IDLE) && start && !cancel && (md_op[3] == 1'b0);

    // Control FSM, latency counter and HI/LO ownership.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            counter_r <= 4'd0;
            hi_r      <= ZERO_W;
            lo_r      <= ZERO_W;
            res_hi_r  <= ZERO_W;
            res_lo_r  <= ZERO_W;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        res_hi_r  <= calc_hi_s;
                        res_lo_r  <= calc_lo_s;
                        counter_r <= is_div_op_s ? DIV_LOAD : MUL_LOAD;
                        state_r   <= is_div_op_s ? ST_DIV : ST_MUL;
                        busy_r    <= 1'b1;
                    end else if (!cancel && (md_op == 4'd8)) begin
                        hi_r <= src_a;
                    end else if (!cancel && (md_op == 4'd9)) begin
                        lo_r <= src_a;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cancel) begin
                        state_r   <= ST_IDLE;
                        counter_r <= 4'd0;
                        busy_r    <= 1'b0;
                    end else if (counter_r == 4'd0) begin
                        hi_r    <= res_hi_r;
                        lo_r    <= res_lo_r;
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        counter_r <= counter_r - 4'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    counter_r <= 4'd0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_md_unit_param.sv
// -----------------------------------------------------------------------------
// tb_md_unit_param
// Self-checking bench for md_unit_param: a default 32-bit instance and a
// 16-bit instance with MUL_LAT=1, DIV_LAT=3. Expected HI/LO come from an
// arithmetic reference model using 64-bit integers.
// -----------------------------------------------------------------------------
module tb_md_unit_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start32 = 1'b0;
    logic [3:0]  op32 = 4'd15;
    logic [31:0] a32 = 32'd0;
    logic [31:0] b32 = 32'd0;
    logic        cancel32 = 1'b0;
    logic        busy32, done32;
    logic [31:0] hi32, lo32;

    logic        start16 = 1'b0;
    logic [3:0]  op16 = 4'd15;
    logic [15:0] a16 = 16'd0;
    logic [15:0] b16 = 16'd0;
    logic        cancel16 = 1'b0;
    logic        busy16, done16;
    logic [15:0] hi16, lo16;

    int n_checks = 0;
    int n_fail   = 0;

    longint unsigned m_hi32 = 0, m_lo32 = 0, m_hi16 = 0, m_lo16 = 0;

    md_unit_param dut32 (
        .clk(clk), .reset(reset), .start(start32), .md_op(op32),
        .src_a(a32), .src_b(b32), .cancel(cancel32),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    md_unit_param #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(3)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .md_op(op16),
        .src_a(a16), .src_b(b16), .cancel(cancel16),
        .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sign-interpret a w-bit value.
    function automatic longint sx(input longint unsigned x, input int w);
        if (((x >> (w - 1)) & 64'd1) != 64'd0) return longint'(x) - (64'sd1 <<< w);
        return longint'(x);
    endfunction

    // Reference model: new {hi,lo} after op with operands a,b, width w.
    function automatic void model(input int w, input int op,
                                  input longint unsigned a, input longint unsigned b,
                                  input longint unsigned hi, input longint unsigned lo,
                                  output longint unsigned nhi, output longint unsigned nlo);
        longint unsigned mask  = (64'd1 << w) - 64'd1;
        longint unsigned mask2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        longint sa = sx(a, w);
        longint sb = sx(b, w);
        longint unsigned acc = (hi << w) | lo;
        longint unsigned prod;
        longint unsigned r;
        nhi = hi;
        nlo = lo;
        if (op == 0 || op == 4 || op == 6) prod = longint'(sa * sb);
        else prod = a * b;
        case (op)
            0, 1, 4, 5, 6, 7: begin
                if (op == 0 || op == 1) r = prod;
                else if (op == 4 || op == 5) r = acc + prod;
                else r = acc - prod;
                r   = r & mask2;
                nhi = (r >> w) & mask;
                nlo = r & mask;
            end
            2: begin
                if (b == 0) begin nlo = mask; nhi = a; end
                else if (sa == -(64'sd1 <<< (w - 1)) && sb == -64'sd1) begin
                    nlo = 64'd1 << (w - 1); nhi = 0;
                end else begin
                    nlo = longint'(sa / sb) & mask;
                    nhi = longint'(sa % sb) & mask;
                end
            end
            3: begin
                if (b == 0) begin nlo = mask; nhi = a; end
                else begin nlo = a / b; nhi = a % b; end
            end
            8: nhi = a;
            9: nlo = a;
            default: ;
        endcase
    endfunction

    task automatic step32(input int op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned nh, nl;
        model(32, op, a, b, m_hi32, m_lo32, nh, nl);
        m_hi32 = nh; m_lo32 = nl;
    endtask

    task automatic step16(input int op, input logic [15:0] a, input logic [15:0] b);
        longint unsigned nh, nl;
        model(16, op, a, b, m_hi16, m_lo16, nh, nl);
        m_hi16 = nh; m_lo16 = nl;
    endtask

    // Issue an op on the 32-bit unit; report busy cycles and done pulses seen.
    task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output int dones);
        @(negedge clk);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(negedge clk);
        start32 = 1'b0; op32 = 4'd15;
        cycles = 0; dones = 0;
        while (busy32 && cycles < 64) begin
            cycles++;
            if (done32) dones++;
            @(negedge clk);
        end
        if (done32) dones++;
        repeat (3) begin
            @(negedge clk);
            if (done32) dones++;
        end
    endtask

    task automatic run16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int cycles, output int dones);
        @(negedge clk);
        start16 = 1'b1; op16 = op; a16 = a; b16 = b;
        @(negedge clk);
        start16 = 1'b0; op16 = 4'd15;
        cycles = 0; dones = 0;
        while (busy16 && cycles < 64) begin
            cycles++;
            if (done16) dones++;
            @(negedge clk);
        end
        if (done16) dones++;
        repeat (3) begin
            @(negedge clk);
            if (done16) dones++;
        end
    endtask

    // Apply mthi/mtlo to the 32-bit unit for one edge.
    task automatic mt32(input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        start32 = 1'b0; op32 = op; a32 = a;
        @(negedge clk);
        op32 = 4'd15;
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (hi32 !== 32'd0 || lo32 !== 32'd0) begin
            $display("FAIL reset_hilo: hi=%h lo=%h, required 0/0", hi32, lo32); n_fail++; end
        n_checks++; if (busy32 !== 1'b0 || done32 !== 1'b0) begin
            $display("FAIL reset_ctrl: busy=%b done=%b, required 0/0", busy32, done32); n_fail++; end
        n_checks++; if (hi16 !== 16'd0 || lo16 !== 16'd0 || busy16 !== 1'b0 || done16 !== 1'b0) begin
            $display("FAIL reset_16: hi=%h lo=%h busy=%b done=%b, required zeros", hi16, lo16, busy16, done16); n_fail++; end
        reset = 1'b0;
        m_hi32 = 0; m_lo32 = 0; m_hi16 = 0; m_lo16 = 0;
    endtask

    task automatic test_mult();
        int cyc, dn;
        step32(0, 32'hFFFF_FFFE, 32'd3);
        run32(4'd0, 32'hFFFF_FFFE, 32'd3, cyc, dn);
        n_checks++; if (cyc != 5) begin $display("FAIL mult_latency: %0d busy cycles, required 5", cyc); n_fail++; end
        n_checks++; if (dn != 1) begin $display("FAIL mult_done: %0d pulses, required 1", dn); n_fail++; end
        n_checks++; if (hi32 !== 32'hFFFF_FFFF || lo32 !== 32'hFFFF_FFFA) begin
            $display("FAIL mult_result: hi=%h lo=%h, required ffffffff/fffffffa", hi32, lo32); n_fail++; end
    endtask

    task automatic test_div();
        int cyc, dn;
        step32(3, 32'd100, 32'd7);
        run32(4'd3, 32'd100, 32'd7, cyc, dn);
        n_checks++; if (cyc != 10) begin $display("FAIL divu_latency: %0d busy cycles, required 10", cyc); n_fail++; end
        n_checks++; if (lo32 !== 32'd14 || hi32 !== 32'd2) begin
            $display("FAIL divu_result: hi=%0d lo=%0d, required 2/14", hi32, lo32); n_fail++; end
        step32(2, 32'hFFFF_FFF9, 32'd2);
        run32(4'd2, 32'hFFFF_FFF9, 32'd2, cyc, dn);
        n_checks++; if (lo32 !== 32'hFFFF_FFFD || hi32 !== 32'hFFFF_FFFF) begin
            $display("FAIL div_signed: hi=%h lo=%h, required ffffffff/fffffffd", hi32, lo32); n_fail++; end
        step32(2, 32'h8000_0000, 32'hFFFF_FFFF);
        run32(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc, dn);
        n_checks++; if (lo32 !== 32'h8000_0000 || hi32 !== 32'd0) begin
            $display("FAIL div_overflow: hi=%h lo=%h, required 0/80000000", hi32, lo32); n_fail++; end
        step32(3, 32'd5, 32'd0);
        run32(4'd3, 32'd5, 32'd0, cyc, dn);
        n_checks++; if (lo32 !== 32'hFFFF_FFFF || hi32 !== 32'd5) begin
            $display("FAIL divu_by_zero: hi=%h lo=%h, required 5/ffffffff", hi32, lo32); n_fail++; end
    endtask

    task automatic test_accumulate();
        int cyc, dn;
        mt32(4'd8, 32'd0);           step32(8, 32'd0, 32'd0);
        mt32(4'd9, 32'hFFFF_FFFF);   step32(9, 32'hFFFF_FFFF, 32'd0);
        n_checks++; if (hi32 !== 32'd0 || lo32 !== 32'hFFFF_FFFF) begin
            $display("FAIL mthi_mtlo: hi=%h lo=%h, required 0/ffffffff", hi32, lo32); n_fail++; end
        step32(5, 32'd1, 32'd1);
        run32(4'd5, 32'd1, 32'd1, cyc, dn);
        n_checks++; if (hi32 !== 32'd1 || lo32 !== 32'd0 || cyc != 5) begin
            $display("FAIL maddu: hi=%h lo=%h cycles=%0d, required 1/0 5", hi32, lo32, cyc); n_fail++; end
        step32(6, 32'd1, 32'd2);
        run32(4'd6, 32'd1, 32'd2, cyc, dn);
        n_checks++; if (hi32 !== 32'd0 || lo32 !== 32'hFFFF_FFFE) begin
            $display("FAIL msub: hi=%h lo=%h, required 0/fffffffe", hi32, lo32); n_fail++; end
    endtask

    task automatic test_random();
        int cyc, dn, op, lat;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            a = pick32(); b = pick32();
            step32(op, a, b);
            if (op >= 8) begin
                mt32(4'(op), a);
            end else begin
                run32(4'(op), a, b, cyc, dn);
                lat = (op == 2 || op == 3) ? 10 : 5;
                n_checks++; if (cyc != lat || dn != 1) begin
                    $display("FAIL rand_timing op=%0d: cycles=%0d dones=%0d, required %0d/1", op, cyc, dn, lat); n_fail++; end
            end
            n_checks++; if (hi32 !== m_hi32[31:0] || lo32 !== m_lo32[31:0]) begin
                $display("FAIL rand_result op=%0d a=%h b=%h: hi=%h lo=%h, required %h/%h",
                         op, a, b, hi32, lo32, m_hi32[31:0], m_lo32[31:0]); n_fail++; end
        end
    endtask

    task automatic test_cancel();
        int dn;
        mt32(4'd8, 32'h1234_5678); step32(8, 32'h1234_5678, 32'd0);
        mt32(4'd9, 32'h9ABC_DEF0); step32(9, 32'h9ABC_DEF0, 32'd0);
        @(negedge clk);
        start32 = 1'b1; op32 = 4'd0; a32 = 32'd7; b32 = 32'd9;
        @(negedge clk);                      // busy cycle 1
        start32 = 1'b0; op32 = 4'd15;
        @(negedge clk);                      // busy cycle 2
        @(negedge clk);                      // busy cycle 3
        n_checks++; if (busy32 !== 1'b1) begin $display("FAIL cancel_pre_busy: busy=%b, required 1", busy32); n_fail++; end
        cancel32 = 1'b1;
        @(negedge clk);
        cancel32 = 1'b0;
        n_checks++; if (busy32 !== 1'b0) begin $display("FAIL cancel_busy: busy=%b, required 0", busy32); n_fail++; end
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (done32) dn++;
            @(negedge clk);
        end
        n_checks++; if (dn != 0) begin $display("FAIL cancel_done: %0d pulses, required 0", dn); n_fail++; end
        n_checks++; if (hi32 !== 32'h1234_5678 || lo32 !== 32'h9ABC_DEF0) begin
            $display("FAIL cancel_hilo: hi=%h lo=%h, required 12345678/9abcdef0", hi32, lo32); n_fail++; end

        // start together with cancel in IDLE, then mthi with cancel
        start32 = 1'b1; op32 = 4'd1; a32 = 32'd3; b32 = 32'd3; cancel32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0; op32 = 4'd8; a32 = 32'hDEAD_BEEF;
        @(negedge clk);
        op32 = 4'd15; cancel32 = 1'b0;
        n_checks++; if (busy32 !== 1'b0 || hi32 !== 32'h1234_5678) begin
            $display("FAIL cancel_idle: busy=%b hi=%h, required 0/12345678", busy32, hi32); n_fail++; end
    endtask

    task automatic test_mthi_busy();
        int cyc;
        logic [31:0] junk;
        junk = $urandom;
        step32(3, 32'd1000, 32'd33);
        @(negedge clk);
        start32 = 1'b1; op32 = 4'd3; a32 = 32'd1000; b32 = 32'd33;
        @(negedge clk);
        start32 = 1'b0; op32 = 4'd8; a32 = junk;
        @(negedge clk);
        op32 = 4'd9;
        @(negedge clk);
        op32 = 4'd15;
        cyc = 0;
        while (busy32 && cyc < 64) begin cyc++; @(negedge clk); end
        n_checks++; if (hi32 !== m_hi32[31:0] || lo32 !== m_lo32[31:0]) begin
            $display("FAIL mt_while_busy: hi=%h lo=%h, required %h/%h", hi32, lo32, m_hi32[31:0], m_lo32[31:0]); n_fail++; end
    endtask

    task automatic test_undefined();
        for (int op = 10; op < 16; op++) begin
            @(negedge clk);
            start32 = 1'b1; op32 = 4'(op); a32 = $urandom; b32 = $urandom;
            @(negedge clk);
            start32 = 1'b0; op32 = 4'd15;
            n_checks++; if (busy32 !== 1'b0 || hi32 !== m_hi32[31:0] || lo32 !== m_lo32[31:0]) begin
                $display("FAIL undefined_op %0d: busy=%b hi=%h lo=%h", op, busy32, hi32, lo32); n_fail++; end
        end
    endtask

    task automatic test_reset_mid_div();
        @(negedge clk);
        start32 = 1'b1; op32 = 4'd2; a32 = 32'd12345; b32 = 32'd7;
        @(negedge clk);
        start32 = 1'b0; op32 = 4'd15;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi32 = 0; m_lo32 = 0; m_hi16 = 0; m_lo16 = 0;
        n_checks++; if (hi32 !== 32'd0 || lo32 !== 32'd0 || busy32 !== 1'b0 || done32 !== 1'b0) begin
            $display("FAIL reset_mid_div: hi=%h lo=%h busy=%b done=%b, required zeros", hi32, lo32, busy32, done32); n_fail++; end
        repeat (12) @(negedge clk);
        n_checks++; if (hi32 !== 32'd0 || lo32 !== 32'd0) begin
            $display("FAIL reset_mid_div_late: hi=%h lo=%h, required 0/0", hi32, lo32); n_fail++; end
    endtask

    task automatic test_param16();
        int cyc, dn, op;
        logic [15:0] a, b;
        step16(1, 16'hFFFF, 16'hFFFF);
        run16(4'd1, 16'hFFFF, 16'hFFFF, cyc, dn);
        n_checks++; if (cyc != 1 || dn != 1) begin
            $display("FAIL p16_mul_timing: cycles=%0d dones=%0d, required 1/1", cyc, dn); n_fail++; end
        n_checks++; if (hi16 !== 16'hFFFE || lo16 !== 16'h0001) begin
            $display("FAIL p16_multu: hi=%h lo=%h, required fffe/0001", hi16, lo16); n_fail++; end
        a = $urandom; b = 16'($urandom_range(1, 65535));
        step16(3, a, b);
        run16(4'd3, a, b, cyc, dn);
        n_checks++; if (cyc != 3 || hi16 !== m_hi16[15:0] || lo16 !== m_lo16[15:0]) begin
            $display("FAIL p16_divu: cycles=%0d hi=%h lo=%h, required 3 %h/%h", cyc, hi16, lo16, m_hi16[15:0], m_lo16[15:0]); n_fail++; end
        for (int i = 0; i < 16; i++) begin
            op = $urandom_range(0, 7);
            a = $urandom; b = (i % 5 == 0) ? 16'h0000 : 16'($urandom);
            step16(op, a, b);
            run16(4'(op), a, b, cyc, dn);
            n_checks++; if (hi16 !== m_hi16[15:0] || lo16 !== m_lo16[15:0] || dn != 1) begin
                $display("FAIL p16_rand op=%0d a=%h b=%h: hi=%h lo=%h dones=%0d, required %h/%h 1",
                         op, a, b, hi16, lo16, dn, m_hi16[15:0], m_lo16[15:0]); n_fail++; end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_accumulate();
        test_random();
        test_cancel();
        test_mthi_busy();
        test_undefined();
        test_reset_mid_div();
        test_param16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
